// File: rtl/inst_adr_table_if.sv
// Lookup/result/load channels of the opcode-to-template-address table.
// Every channel uses valid/ready: a transfer happens on a rising clk edge where both are 1;
// the source holds valid and payload stable until that edge, and ready may depend on valid.
interface inst_adr_table_if #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 7
);
    logic             lk_valid;
    logic             lk_ready;
    logic [IN_W-1:0]  lk_index;
    logic             rs_valid;
    logic             rs_ready;
    logic [OUT_W-1:0] rs_addr;
    logic             rs_miss;
    logic             ld_valid;
    logic             ld_ready;
    logic [IN_W-1:0]  ld_index;
    logic [OUT_W-1:0] ld_data;
    logic             ld_clear;

    modport master (
        output lk_valid, lk_index, rs_ready, ld_valid, ld_index, ld_data, ld_clear,
        input  lk_ready, rs_valid, rs_addr, rs_miss, ld_ready
    );

    modport slave (
        input  lk_valid, lk_index, rs_ready, ld_valid, ld_index, ld_data, ld_clear,
        output lk_ready, rs_valid, rs_addr, rs_miss, ld_ready
    );
endinterface

// File: rtl/inst_adr_table.sv
// Opcode index -> template address table with valid bits, swept clear after reset.
// Optional INST_ADR_TABLE_STATS_EN adds saturating hit/miss counters.
module inst_adr_table #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_adr_table_if.slave   bus,
    output logic              busy,
    output logic              dbg_state
`ifdef INST_ADR_TABLE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);
    localparam int DEPTH = 2**IN_W;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t           state, state_nx;
    logic [IN_W-1:0]  clr_cnt;
    logic             run;

    logic [OUT_W-1:0] tbl_data [DEPTH];
    logic [DEPTH-1:0] tbl_vld;

    logic             lk_fire, ld_fire, byp, look_hit;
    logic [OUT_W-1:0] look_data;

    logic             rs_valid_q, rs_miss_q;
    logic [OUT_W-1:0] rs_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        run      = 1'b0;
        case (state)
            ST_INIT: if (clr_cnt == {IN_W{1'b1}}) state_nx = ST_RUN;
            ST_RUN: begin
                busy = 1'b0;
                run  = 1'b1;
            end
            default: state_nx = ST_INIT;
        endcase
    end

    assign dbg_state    = state;
    assign bus.ld_ready = run;
    assign bus.lk_ready = run && (!rs_valid_q || bus.rs_ready);
    assign lk_fire      = bus.lk_valid && bus.lk_ready;
    assign ld_fire      = bus.ld_valid && run;

    // Valid bits are swept during INIT, so neither array needs a reset term.
    always_ff @(posedge clk) begin
        if (state == ST_INIT)  tbl_vld[clr_cnt]      <= 1'b0;
        else if (ld_fire)      tbl_vld[bus.ld_index] <= !bus.ld_clear;
    end

    always_ff @(posedge clk) begin
        if (ld_fire && !bus.ld_clear) tbl_data[bus.ld_index] <= bus.ld_data;
    end

    // A write landing on the index being looked up wins over the stored entry.
    always_comb begin
        byp = ld_fire && (bus.ld_index == bus.lk_index);
        if (byp) begin
            look_hit  = !bus.ld_clear;
            look_data = bus.ld_data;
        end else begin
            look_hit  = tbl_vld[bus.lk_index];
            look_data = tbl_data[bus.lk_index];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid_q <= 1'b0;
            rs_miss_q  <= 1'b0;
            rs_addr_q  <= '0;
        end else if (lk_fire) begin
            rs_valid_q <= 1'b1;
            rs_miss_q  <= !look_hit;
            rs_addr_q  <= look_hit ? look_data : {OUT_W{1'b1}};
        end else if (bus.rs_ready) begin
            rs_valid_q <= 1'b0;
        end
    end

    assign bus.rs_valid = rs_valid_q;
    assign bus.rs_miss  = rs_miss_q;
    assign bus.rs_addr  = rs_addr_q;

`ifdef INST_ADR_TABLE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (lk_fire) begin
            if (look_hit) begin
                if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif
endmodule
